beam_scan_sequencer: RTL and testbench

Scan controller for the 16-mic delay-and-sum beamformer. It generates the shared PDM microphone clock and its per-sample strobe. It steps the steering direction index through 0..num_dirs, running a settle period and then an integration window per direction. Each window's result is offered to the readout logic with a valid/ready handshake.

---
 rtl/beam_pkg.sv | 22 ++
 rtl/beam_scan_sequencer_if.sv | 34 +++
 rtl/beam_scan_sequencer_pdm_clk_gen.sv | 52 +++++
 rtl/beam_scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_beam_scan_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/beam_pkg.sv
// ---------------------------------------------------------------------------
// beam_pkg
// Shared definitions for the beamformer scan controller: the scan state
// encoding and the default divider / settle / width constants. The widths are
// also used by the delay table (direction index) and the accumulator
// (window length).
// ---------------------------------------------------------------------------
package beam_pkg;

  localparam int BEAM_CLK_DIV = 4;   // system clocks per PDM half-period
  localparam int BEAM_SETTLE  = 16;  // PDM samples discarded after a direction change
  localparam int BEAM_DIR_W   = 4;   // direction index width
  localparam int BEAM_WIN_W   = 10;  // integration window counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_INTEG  = 2'd2,
    ST_RESULT = 2'd3
  } beam_state_e;

endpackage

// File: rtl/beam_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// beam_scan_sequencer_if
// Window-result handshake between the scan sequencer and the readout logic.
//   res_valid  sequencer -> readout  result of the current window is valid
//   res_ready  readout -> sequencer  readout accepts the result this cycle
//   dir_idx    sequencer -> readout  steering direction of the window
//   scan_done  sequencer -> readout  pulse after the last direction is accepted
// ---------------------------------------------------------------------------
interface beam_scan_sequencer_if
  import beam_pkg::*;
#(
  parameter int DIR_W = BEAM_DIR_W
) ();

  logic             res_valid;
  logic             res_ready;
  logic [DIR_W-1:0] dir_idx;
  logic             scan_done;

  modport master (
    output res_valid,
    output dir_idx,
    output scan_done,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  dir_idx,
    input  scan_done,
    output res_ready
  );

endinterface

// File: rtl/beam_scan_sequencer_pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen
// Free-running PDM microphone clock divider.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        low = synchronous clear of divider, pdm_clk and sample_en
//   pdm_clk    microphone clock, period 2*CLK_DIV system clocks
//   sample_en  1-cycle pulse in the first system cycle pdm_clk is high
// ---------------------------------------------------------------------------
module pdm_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic pdm_clk,
  output logic sample_en
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic          pdm_clk_q;
  logic          sample_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      pdm_clk_q   <= 1'b0;
      sample_en_q <= 1'b0;
    end else if (!ena) begin
      div_cnt_q   <= '0;
      pdm_clk_q   <= 1'b0;
      sample_en_q <= 1'b0;
    end else begin
      sample_en_q <= 1'b0;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_q   <= '0;
        pdm_clk_q   <= ~pdm_clk_q;
        // Strobe coincides with the registered rising edge of pdm_clk.
        sample_en_q <= ~pdm_clk_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  assign pdm_clk   = pdm_clk_q;
  assign sample_en = sample_en_q;

endmodule

// File: rtl/beam_scan_sequencer.sv
// ---------------------------------------------------------------------------
// beam_scan_sequencer
// Scan controller for the 16-mic delay-and-sum beamformer. Steps the steering
// direction through 0..num_dirs; each direction runs a settle period (delay
// line refill) followed by an integration window, whose result is offered
// to the readout over a valid/ready handshake.
//   clk, rst_n    system clock, asynchronous active-low reset
//   ena           low = soft reset of everything except latched config
//   start, abort  begin scan / return to IDLE (abort wins)
//   cont          continuous mode, sampled at the last direction's handshake
//   num_dirs      index of last direction (latched at start)
//   win_len       samples per window, 0 behaves as 1 (latched at start)
//   pdm_clk, sample_en       microphone clock and per-sample strobe
//   sample_gate, acc_clr     accumulator gate and clear pulse
//   busy                     high in every state except IDLE
//   res_if                   result handshake, dir_idx, scan_done
// ---------------------------------------------------------------------------
module beam_scan_sequencer
  import beam_pkg::*;
#(
  parameter int CLK_DIV = BEAM_CLK_DIV,
  parameter int DIR_W   = BEAM_DIR_W,
  parameter int WIN_W   = BEAM_WIN_W,
  parameter int SETTLE  = BEAM_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [DIR_W-1:0]      num_dirs,
  input  logic [WIN_W-1:0]      win_len,
  output logic                  pdm_clk,
  output logic                  sample_en,
  output logic                  sample_gate,
  output logic                  acc_clr,
  output logic                  busy,
  beam_scan_sequencer_if.master res_if
);

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);

  beam_state_e      state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [DIR_W-1:0] dir_idx_q, dir_idx_d;
  logic             acc_clr_q, acc_clr_d;
  logic             scan_done_q, scan_done_d;
  logic             latch_cfg;
  logic [DIR_W-1:0] num_dirs_q;
  logic [WIN_W-1:0] win_last_q;

  pdm_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pdm_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .pdm_clk  (pdm_clk),
    .sample_en(sample_en)
  );

  // Counters compare against the index of their final sample, so each
  // transition happens on the pulse that completes the count; that pulse
  // still belongs to the state being left.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_idx_d   = dir_idx_q;
    acc_clr_d   = 1'b0;
    scan_done_d = 1'b0;
    latch_cfg   = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      dir_idx_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_SETTLE;
            cnt_d     = '0;
            dir_idx_d = '0;
            latch_cfg = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (sample_en) begin
            if (cnt_q == SETTLE_LAST) begin
              state_d   = ST_INTEG;
              cnt_d     = '0;
              acc_clr_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_INTEG: begin
          if (sample_en) begin
            if (cnt_q == win_last_q) begin
              state_d = ST_RESULT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RESULT: begin
          // Strobes while stalled here are intentionally ignored.
          if (res_if.res_ready) begin
            cnt_d = '0;
            if (dir_idx_q == num_dirs_q) begin
              scan_done_d = 1'b1;
              dir_idx_d   = '0;
              state_d     = cont ? ST_SETTLE : ST_IDLE;
            end else begin
              dir_idx_d = dir_idx_q + 1'b1;
              state_d   = ST_SETTLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_idx_q   <= '0;
      acc_clr_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else if (!ena) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_idx_q   <= '0;
      acc_clr_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_idx_q   <= dir_idx_d;
      acc_clr_q   <= acc_clr_d;
      scan_done_q <= scan_done_d;
    end
  end

  // Scan configuration survives the ena soft reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_dirs_q <= '0;
      win_last_q <= '0;
    end else if (ena && latch_cfg) begin
      num_dirs_q <= num_dirs;
      win_last_q <= (win_len == '0) ? '0 : win_len - 1'b1;
    end
  end

  assign sample_gate      = (state_q == ST_INTEG);
  assign acc_clr          = acc_clr_q;
  assign busy             = (state_q != ST_IDLE);
  assign res_if.res_valid = (state_q == ST_RESULT);
  assign res_if.dir_idx   = dir_idx_q;
  assign res_if.scan_done = scan_done_q;

endmodule

// File: tb/tb_beam_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beam_scan_sequencer
// Directed bench for beam_scan_sequencer (CLK_DIV=4, SETTLE=16). Outputs are
// sampled and inputs driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_beam_scan_sequencer;
  import beam_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, cont, abort;
  logic [3:0] num_dirs;
  logic [9:0] win_len;
  logic       pdm_clk, sample_en, sample_gate, acc_clr, busy;

  int checks = 0;
  int errors = 0;

  beam_scan_sequencer_if #(.DIR_W(4)) rif ();

  beam_scan_sequencer #(
    .CLK_DIV(4), .DIR_W(4), .WIN_W(10), .SETTLE(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .cont       (cont),
    .abort      (abort),
    .num_dirs   (num_dirs),
    .win_len    (win_len),
    .pdm_clk    (pdm_clk),
    .sample_en  (sample_en),
    .sample_gate(sample_gate),
    .acc_clr    (acc_clr),
    .busy       (busy),
    .res_if     (rif)
  );

  always #5 clk = ~clk;

  // Observes one window from its first SETTLE cycle until res_valid is seen.
  task automatic measure_window(output int settle_n, output int gated_n, output int clr_n,
                                output int first_dir, output int dir_bad, output bit timeout);
    int cyc;
    bit gate_prev;
    settle_n = 0; gated_n = 0; clr_n = 0; dir_bad = 0; timeout = 0; cyc = 0;
    gate_prev = 1'b0;
    first_dir = int'(rif.dir_idx);
    while (rif.res_valid !== 1'b1) begin
      if (sample_en && busy && !sample_gate) settle_n++;
      if (sample_en && sample_gate) gated_n++;
      if (acc_clr && sample_gate && !gate_prev) clr_n++;
      else if (acc_clr) clr_n += 100;  // clear pulse outside the first INTEG cycle
      if (int'(rif.dir_idx) != first_dir) dir_bad++;
      gate_prev = sample_gate;
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin timeout = 1'b1; break; end
    end
    if (int'(rif.dir_idx) != first_dir) dir_bad++;
    $display("window dir=%0d settle=%0d gated=%0d clr=%0d", first_dir, settle_n, gated_n, clr_n);
  endtask

  task automatic pulse_start(input logic [3:0] nd, input logic [9:0] wl);
    num_dirs = nd; win_len = wl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    int idle_bad;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    num_dirs = '0; win_len = '0; rif.res_ready = 1'b0;
    @(negedge clk);
    outs = {pdm_clk, sample_en, sample_gate, acc_clr, busy, rif.res_valid, rif.scan_done, rif.dir_idx};
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", outs); end
    rst_n = 1'b1; ena = 1'b1;
    idle_bad = 0;
    // pdm_clk rises at posedges 4,12,20,28 after release; strobe only there.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checks++;
      if (pdm_clk !== (((k / 4) % 2) == 1)) begin
        errors++; $display("FAIL pdm_clk_k%0d: got %b expected %b", k, pdm_clk, ((k / 4) % 2) == 1);
      end
      checks++;
      if (sample_en !== ((k % 8) == 4)) begin
        errors++; $display("FAIL sample_en_k%0d: got %b expected %b", k, sample_en, (k % 8) == 4);
      end
      if ({sample_gate, acc_clr, busy, rif.res_valid, rif.scan_done} !== 5'd0 || rif.dir_idx !== 4'd0)
        idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin errors++; $display("FAIL idle_outputs: got %0d busy cycles expected 0", idle_bad); end
  endtask

  task automatic test_single_scan();
    int s, g, c, fd, db;
    bit to;
    cont = 1'b0; rif.res_ready = 1'b1;
    pulse_start(4'd2, 10'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    for (int d = 0; d <= 2; d++) begin
      measure_window(s, g, c, fd, db, to);
      checks++;
      if (to) begin errors++; $display("FAIL scan_timeout_d%0d: got timeout expected res_valid", d); end
      checks++;
      if (fd != d || db != 0) begin errors++; $display("FAIL scan_dir_d%0d: got dir %0d (%0d changes) expected %0d", d, fd, db, d); end
      checks++;
      if (s != 16) begin errors++; $display("FAIL scan_settle_d%0d: got %0d expected 16", d, s); end
      checks++;
      if (g != 4) begin errors++; $display("FAIL scan_gated_d%0d: got %0d expected 4", d, g); end
      checks++;
      if (c != 1) begin errors++; $display("FAIL scan_accclr_d%0d: got %0d expected 1", d, c); end
      @(negedge clk);
      checks++;
      if (rif.scan_done !== (d == 2)) begin errors++; $display("FAIL scan_done_d%0d: got %b expected %b", d, rif.scan_done, d == 2); end
      checks++;
      if (busy !== (d != 2)) begin errors++; $display("FAIL scan_busy_d%0d: got %b expected %b", d, busy, d != 2); end
    end
    @(negedge clk);
    checks++;
    if ({busy, rif.scan_done, rif.res_valid} !== 3'b000) begin
      errors++; $display("FAIL scan_end_idle: got %b expected 000", {busy, rif.scan_done, rif.res_valid});
    end
  endtask

  task automatic test_stall();
    int s, g, c, fd, db, bad;
    bit to;
    cont = 1'b0; rif.res_ready = 1'b0;
    pulse_start(4'd1, 10'd2);
    measure_window(s, g, c, fd, db, to);
    checks++;
    if (to || g != 2) begin errors++; $display("FAIL stall_win0: got gated %0d timeout %b expected 2 0", g, to); end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      start = (k == 10);  // start while busy must be ignored
      @(negedge clk);
      if (rif.res_valid !== 1'b1 || rif.dir_idx !== 4'd0 || sample_gate !== 1'b0 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    rif.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.res_valid, busy, sample_gate} !== 3'b010 || rif.dir_idx !== 4'd1) begin
      errors++; $display("FAIL stall_release: got valid/busy/gate %b dir %0d expected 010 dir 1",
                         {rif.res_valid, busy, sample_gate}, rif.dir_idx);
    end
    measure_window(s, g, c, fd, db, to);
    checks++;
    if (to || s != 16 || g != 2 || fd != 1) begin
      errors++; $display("FAIL stall_win1: got settle %0d gated %0d dir %0d expected 16 2 1", s, g, fd);
    end
    @(negedge clk);
    checks++;
    if ({rif.scan_done, busy} !== 2'b10) begin errors++; $display("FAIL stall_done: got %b expected 10", {rif.scan_done, busy}); end
  endtask

  task automatic test_cont();
    int s, g, c, fd, db;
    bit to;
    cont = 1'b1; rif.res_ready = 1'b1;
    pulse_start(4'd1, 10'd1);
    for (int w = 0; w < 4; w++) begin
      measure_window(s, g, c, fd, db, to);
      checks++;
      if (to || fd != (w % 2) || g != 1) begin
        errors++; $display("FAIL cont_win%0d: got dir %0d gated %0d expected %0d 1", w, fd, g, w % 2);
      end
      @(negedge clk);
      checks++;
      if (rif.scan_done !== (w % 2 == 1)) begin errors++; $display("FAIL cont_done_w%0d: got %b expected %b", w, rif.scan_done, w % 2 == 1); end
      checks++;
      if (busy !== (w != 3)) begin errors++; $display("FAIL cont_busy_w%0d: got %b expected %b", w, busy, w != 3); end
      if (w == 1) begin
        checks++;
        if (rif.dir_idx !== 4'd0) begin errors++; $display("FAIL cont_wrap_dir: got %0d expected 0", rif.dir_idx); end
        cont = 1'b0;  // stop at the end of the second sweep
      end
    end
  endtask

  task automatic test_abort();
    int s, g, c, fd, db, bad, cyc;
    bit to;
    cont = 1'b0; rif.res_ready = 1'b1;
    pulse_start(4'd3, 10'd8);
    cyc = 0;
    while (sample_gate !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
    repeat (20) @(negedge clk);
    checks++;
    if (sample_gate !== 1'b1) begin errors++; $display("FAIL abort_in_integ: got gate %b expected 1", sample_gate); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, sample_gate, rif.res_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: got %b expected 000", {busy, sample_gate, rif.res_valid});
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || rif.res_valid || rif.scan_done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    // abort coinciding with the handshake of the last result
    rif.res_ready = 1'b0;
    pulse_start(4'd0, 10'd1);
    measure_window(s, g, c, fd, db, to);
    checks++;
    if (to) begin errors++; $display("FAIL abort_hs_timeout: got timeout expected res_valid"); end
    abort = 1'b1; rif.res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({rif.scan_done, busy, rif.res_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_hs: got done/busy/valid %b expected 000", {rif.scan_done, busy, rif.res_valid});
    end
  endtask

  task automatic test_winzero_reset();
    int s, g, c, fd, db;
    logic [10:0] outs;
    bit to;
    cont = 1'b1; rif.res_ready = 1'b1;
    pulse_start(4'd0, 10'd0);
    measure_window(s, g, c, fd, db, to);
    checks++;
    if (to || g != 1 || s != 16) begin errors++; $display("FAIL win0_gated: got gated %0d settle %0d expected 1 16", g, s); end
    @(negedge clk);
    checks++;
    if ({rif.scan_done, busy} !== 2'b11) begin errors++; $display("FAIL win0_done: got %b expected 11", {rif.scan_done, busy}); end
    rif.res_ready = 1'b0;
    measure_window(s, g, c, fd, db, to);
    checks++;
    if (to || g != 1) begin errors++; $display("FAIL win0_gated2: got %0d expected 1", g); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {pdm_clk, sample_en, sample_gate, acc_clr, busy, rif.res_valid, rif.scan_done, rif.dir_idx};
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL async_reset: got %b expected 0", outs); end
    @(negedge clk);
    cont = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_stall();
    test_cont();
    test_abort();
    test_winzero_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
